serial_adder: RTL

//  Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, LSB first,
//  one bit per clock, through a single full-adder cell. Start/busy/done handshake.

---
 rtl/serial_adder_pkg.sv | 7 +
 rtl/serial_adder_fa_cell.sv | 11 +
 rtl/serial_adder.sv | 101 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter sizing shared by the bit-serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder used by the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);
  assign s = x ^ y ^ z;
  assign c = (x & y) | (z & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/busy/done handshake and signed overflow.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a-b via inverted b and forced carry-in).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE = CW'(WIDTH - 2);
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cmsb_q, cmsb_d, cout_q, cout_d, ovf_q, ovf_d;
  logic fs, fc;
  fa_cell u_fa (.x(opa_q[0]), .y(opb_q[0]), .z(carry_q), .s(fs), .c(fc));
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == RUN) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      acc_d   = {fs, acc_q[WIDTH-1:1]};
      carry_d = fc;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == PRE) cmsb_d = fc;
      if (cnt_q == LAST) begin
        state_d = DONE;
        sum_d   = acc_d;
        cout_d  = fc;
        ovf_d   = cmsb_q ^ fc;
      end
    end else if (start) begin
      state_d = RUN;
      opa_d   = a;
      cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
      opb_d   = sub ? ~b : b;
      carry_d = sub | cin;
`else
      opb_d   = b;
      carry_d = cin;
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule
